// File: rtl/ray_aabb_slab_reduce_pkg.sv
// Shared definitions for the ray/AABB slab reduction: FloPoCo exception codes,
// FSM states and the compare-step sequence.
package ray_aabb_slab_reduce_pkg;

  localparam int FP_W = 19;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] STEP_NEAR_Y = 3'd0;
  localparam logic [2:0] STEP_NEAR_Z = 3'd1;
  localparam logic [2:0] STEP_FAR_Y  = 3'd2;
  localparam logic [2:0] STEP_FAR_Z  = 3'd3;
  localparam logic [2:0] STEP_OK_A   = 3'd4;
  localparam logic [2:0] STEP_OK_B   = 3'd5;

  // Exception field 1x means inf or NaN; such inputs bypass the compare sequence.
  function automatic logic is_special(input logic [FP_W-1:0] v);
    return v[FP_W-1];
  endfunction

endpackage

// File: rtl/ray_aabb_slab_reduce_greater_or_equal.sv
// Pipelined FloPoCo float compare: ge = (x >= y), valid lat cycles after the
// operands settle. Zeros of either sign compare equal; NaN is not expected here.
module greater_or_equal
  import ray_aabb_slab_reduce_pkg::*;
#(
  parameter int width = 18,
  parameter int lat   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [width:0] x,
  input  logic [width:0] y,
  output logic           ge
);

  logic [width:0] mag_x;
  logic [width:0] mag_y;
  logic           neg_x;
  logic           neg_y;
  logic           ge_now;
  logic [lat-1:0] pipe;

  // Magnitude key orders zero < normal < inf, then exponent, then fraction.
  assign mag_x = {x[width:width-1] == EXC_INF, x[width:width-1] != EXC_ZERO, x[width-3:0]};
  assign mag_y = {y[width:width-1] == EXC_INF, y[width:width-1] != EXC_ZERO, y[width-3:0]};
  assign neg_x = x[width-2] && (x[width:width-1] != EXC_ZERO);
  assign neg_y = y[width-2] && (y[width:width-1] != EXC_ZERO);

  always_comb begin
    if (neg_x != neg_y) ge_now = neg_y;
    else if (!neg_x)    ge_now = (mag_x >= mag_y);
    else                ge_now = (mag_x <= mag_y);
  end

  // NOTE: this is a tiny delay line, not a memory, so every stage is reset to a known value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= ge_now;
      for (int i = 1; i < lat; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ge = pipe[lat-1];

endmodule

// File: rtl/ray_aabb_slab_reduce.sv
// Reduces three slab intervals to t_enter = max(tnear), t_exit = min(tfar) and a
// hit flag, sequencing six compares through one shared greater_or_equal.
module ray_aabb_slab_reduce
  import ray_aabb_slab_reduce_pkg::*;
#(
  parameter int width   = 18,
  parameter int CMP_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [width:0] tnear_x,
  input  logic [width:0] tnear_y,
  input  logic [width:0] tnear_z,
  input  logic [width:0] tfar_x,
  input  logic [width:0] tfar_y,
  input  logic [width:0] tfar_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           hit,
  output logic           err,
  output logic [width:0] t_enter,
  output logic [width:0] t_exit
);

  localparam int               CNT_W    = $clog2(CMP_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT);

  state_t         state;
  state_t         state_next;
  logic [2:0]     step;
  logic [CNT_W-1:0] cnt;
  logic [width:0] r_tnear_y, r_tnear_z, r_tfar_y, r_tfar_z;
  logic [width:0] near_max, far_min;
  logic           ok_a;
  logic [width:0] op_a, op_b;
  logic           ge;
  logic           accept;
  logic           any_special;
  logic           step_end;

  assign accept      = in_valid && in_ready;
  assign any_special = is_special(tnear_x) || is_special(tnear_y) || is_special(tnear_z) ||
                       is_special(tfar_x)  || is_special(tfar_y)  || is_special(tfar_z);
  assign step_end    = (cnt == CNT_LAST);

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: each comb block assigns defaults first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = any_special ? ST_DONE : ST_RUN;
      ST_RUN:  if (step_end && step == STEP_OK_B) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Operands depend only on registered state, so they hold for a whole step.
  always_comb begin
    op_a = far_min;
    op_b = FP_ZERO;
    case (step)
      STEP_NEAR_Y: begin op_a = r_tnear_y; op_b = near_max; end
      STEP_NEAR_Z: begin op_a = r_tnear_z; op_b = near_max; end
      STEP_FAR_Y:  begin op_a = r_tfar_y;  op_b = far_min;  end
      STEP_FAR_Z:  begin op_a = r_tfar_z;  op_b = far_min;  end
      STEP_OK_A:   begin op_a = far_min;   op_b = near_max; end
      default:     begin op_a = far_min;   op_b = FP_ZERO;  end
    endcase
  end

  greater_or_equal #(.width(width), .lat(CMP_LAT)) u_ge (
    .clk (clk),
    .rst (~rst),
    .x   (op_a),
    .y   (op_b),
    .ge  (ge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step      <= '0;
      cnt       <= '0;
      r_tnear_y <= '0;
      r_tnear_z <= '0;
      r_tfar_y  <= '0;
      r_tfar_z  <= '0;
      near_max  <= '0;
      far_min   <= '0;
      ok_a      <= 1'b0;
      hit       <= 1'b0;
      err       <= 1'b0;
      t_enter   <= '0;
      t_exit    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_tnear_y <= tnear_y;
            r_tnear_z <= tnear_z;
            r_tfar_y  <= tfar_y;
            r_tfar_z  <= tfar_z;
            near_max  <= tnear_x;
            far_min   <= tfar_x;
            step      <= STEP_NEAR_Y;
            cnt       <= '0;
            if (any_special) begin
              err     <= 1'b1;
              hit     <= 1'b0;
              t_enter <= '0;
              t_exit  <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!step_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            case (step)
              STEP_NEAR_Y: if (ge)  near_max <= r_tnear_y;
              STEP_NEAR_Z: if (ge)  near_max <= r_tnear_z;
              STEP_FAR_Y:  if (!ge) far_min  <= r_tfar_y;
              STEP_FAR_Z:  if (!ge) far_min  <= r_tfar_z;
              STEP_OK_A:   ok_a <= ge;
              default: begin
                hit     <= ok_a && ge;
                err     <= 1'b0;
                t_enter <= near_max;
                t_exit  <= far_min;
              end
            endcase
            step <= (step == STEP_OK_B) ? STEP_NEAR_Y : step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_aabb_slab_reduce.sv
// Directed bench for ray_aabb_slab_reduce: hand-computed slab cases, the
// inf/NaN bypass, output back-pressure and an asynchronous reset mid-job.
module tb_ray_aabb_slab_reduce;

  localparam logic [18:0] H0_5 = 19'h27000;
  localparam logic [18:0] H1   = 19'h27800;
  localparam logic [18:0] H2   = 19'h28000;
  localparam logic [18:0] H3   = 19'h28400;
  localparam logic [18:0] H4   = 19'h28800;
  localparam logic [18:0] HM1  = 19'h37800;
  localparam logic [18:0] HM2  = 19'h38000;
  localparam logic [18:0] HNAN = 19'h60000;
  localparam logic [18:0] HZ   = 19'h00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] tnear_x = '0, tnear_y = '0, tnear_z = '0;
  logic [18:0] tfar_x = '0, tfar_y = '0, tfar_z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        hit, err;
  logic [18:0] t_enter, t_exit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ray_aabb_slab_reduce #(.width(18), .CMP_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .tnear_x(tnear_x), .tnear_y(tnear_y), .tnear_z(tnear_z),
    .tfar_x(tfar_x), .tfar_y(tfar_y), .tfar_z(tfar_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .err(err), .t_enter(t_enter), .t_exit(t_exit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one job and lets it be accepted on the next rising edge.
  // Returns sampled #1 after the accept edge.
  task automatic start_job(input logic [18:0] nx, ny, nz, fx, fy, fz);
    tnear_x = nx; tnear_y = ny; tnear_z = nz;
    tfar_x  = fx; tfar_y  = fy; tfar_z  = fz;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(input string tag, input int exp_edges);
    int edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, edges, exp_edges);
  endtask

  task automatic check_result(input string tag, input logic [18:0] te, tx,
                              input logic h, e);
    check({tag, "_valid"},   out_valid, 1'b1);
    check({tag, "_t_enter"}, t_enter, te);
    check({tag, "_t_exit"},  t_exit, tx);
    check({tag, "_hit"},     hit, h);
    check({tag, "_err"},     err, e);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    #20;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_t_enter", t_enter, 19'h0);
    check("rst_t_exit", t_exit, 19'h0);
    @(negedge clk);

    // 1: enter at 1.0, exit at 2.0, hit
    start_job(H0_5, H1, HM1, H3, H2, H4);
    check("c1_busy", in_ready, 1'b0);
    wait_result("c1", 24);
    check_result("c1", H1, H2, 1'b1, 1'b0);
    handshake("c1");

    // 2: enter 2.0 after exit 1.0, miss; in_valid held high with junk while busy
    start_job(H2, H0_5, H0_5, H3, H1, H4);
    in_valid = 1'b1;
    tnear_x = H4; tnear_y = H4; tnear_z = H4;
    tfar_x = HZ;  tfar_y = HZ;  tfar_z = HZ;
    wait_result("c2", 24);
    in_valid = 1'b0;
    check_result("c2", H2, H1, 1'b0, 1'b0);
    handshake("c2");

    // 3: interval entirely behind the origin
    start_job(HM2, HM2, HM2, HM1, HM1, HM1);
    wait_result("c3", 24);
    check_result("c3", HM2, HM1, 1'b0, 1'b0);
    handshake("c3");

    // 4: all zero, ties resolve as >=
    start_job(HZ, HZ, HZ, HZ, HZ, HZ);
    wait_result("c4", 24);
    check_result("c4", HZ, HZ, 1'b1, 1'b0);
    handshake("c4");

    // 5: NaN input; valid in the cycle right after the accept edge
    start_job(H0_5, H1, HM1, H3, HNAN, H4);
    wait_result("c5", 0);
    check_result("c5", HZ, HZ, 1'b0, 1'b1);
    handshake("c5");

    // 6a: back-pressure holds the result
    start_job(H0_5, H1, HM1, H3, H2, H4);
    wait_result("c6", 24);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_result($sformatf("c6_hold%0d", i), H1, H2, 1'b1, 1'b0);
      check($sformatf("c6_hold%0d_in_ready", i), in_ready, 1'b0);
    end
    handshake("c6");

    // 6b: async reset mid-run discards the job
    start_job(H2, H0_5, H0_5, H3, H1, H4);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("c6_rst_valid", out_valid, 1'b0);
    check("c6_rst_ready", in_ready, 1'b1);
    check("c6_rst_t_enter", t_enter, 19'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    repeat (30) begin
      @(posedge clk);
      #1;
      check("c6_no_ghost", out_valid, 1'b0);
    end
    @(negedge clk);
    start_job(H2, H0_5, H0_5, H3, H1, H4);
    wait_result("c6_fresh", 24);
    check_result("c6_fresh", H2, H1, 1'b0, 1'b0);
    handshake("c6_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
